// File: rtl/iomem_dma_if.sv
// Generic iomem bus bundle: one requester (master) and one responder (slave).
// ADDR_W lets the same bundle serve the narrow config port and the full
// 32-bit initiator port.
interface iomem_dma_if #(
    parameter int ADDR_W = 32
);
    logic              valid;
    logic              ready;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;

    modport master (
        output valid,
        output wstrb,
        output addr,
        output wdata,
        input  ready,
        input  rdata
    );

    modport slave (
        input  valid,
        input  wstrb,
        input  addr,
        input  wdata,
        output ready,
        output rdata
    );
endinterface

// File: rtl/iomem_dma.sv
// iomem word-copy DMA: reads a word at SRC, writes it to DST, repeats LEN
// times. Config registers sit on a responder port; copies run on an
// initiator port shared with the CPU through the top-level arbiter.
module iomem_dma #(
    parameter int LEN_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    iomem_dma_if.slave  i_cfg,
    iomem_dma_if.master o_mst,
    output logic       o_irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [31:0]        r_src;
    logic [31:0]        r_dst;
    logic [31:0]        r_buf;
    logic [LEN_W-1:0]   r_len;
    logic               r_done;
    logic               r_aborted;
    logic               r_dstFixed;
    logic               r_abortReq;
    logic               r_irq;

    logic               w_busy;
    logic               w_cfgWrite;
    logic               w_wrSrc;
    logic               w_wrDst;
    logic               w_wrLen;
    logic               w_wrCtrl;
    logic               w_start;
    logic               w_abortWr;
    logic               w_clearSticky;
    logic               w_abortNow;
    logic               w_hs;
    logic [LEN_W-1:0]   w_lenNext;

    logic               w_launch;
    logic               w_emptyStart;
    logic               w_capture;
    logic               w_wordDone;
    logic               w_finish;
    logic               w_abortDone;

    assign w_busy        = (r_state != S_IDLE);
    assign w_cfgWrite    = i_cfg.valid && (i_cfg.wstrb != 4'h0);
    assign w_wrSrc       = w_cfgWrite && (i_cfg.addr[3:0] == 4'h0);
    assign w_wrDst       = w_cfgWrite && (i_cfg.addr[3:0] == 4'h4);
    assign w_wrLen       = w_cfgWrite && (i_cfg.addr[3:0] == 4'h8);
    assign w_wrCtrl      = w_cfgWrite && (i_cfg.addr[3:0] == 4'hC);
    assign w_start       = w_wrCtrl && i_cfg.wdata[0] && !w_busy;
    assign w_abortWr     = w_wrCtrl && i_cfg.wdata[2];
    assign w_clearSticky = w_wrCtrl && i_cfg.wdata[3];
    // An abort arriving in the same cycle as the handshake still stops the copy.
    assign w_abortNow    = r_abortReq || w_abortWr;
    assign w_hs          = w_busy && o_mst.ready;
    assign w_lenNext     = r_len - 1'b1;

    assign i_cfg.ready   = i_cfg.valid;
    assign o_irq         = r_irq;

    // Config read mux; reads during a copy show the live working counters.
    always_comb begin
        i_cfg.rdata = 32'h0;
        case (i_cfg.addr[3:0])
            4'h0:    i_cfg.rdata = r_src;
            4'h4:    i_cfg.rdata = r_dst;
            4'h8:    i_cfg.rdata = {{(32-LEN_W){1'b0}}, r_len};
            4'hC:    i_cfg.rdata = {28'h0, r_dstFixed, r_aborted, r_done, w_busy};
            default: i_cfg.rdata = 32'h0;
        endcase
    end

    // Next-state and bus-drive logic; bus outputs depend only on registers,
    // so they stay put for as long as a responder stalls.
    always_comb begin
        w_stateNext  = r_state;
        w_launch     = 1'b0;
        w_emptyStart = 1'b0;
        w_capture    = 1'b0;
        w_wordDone   = 1'b0;
        w_finish     = 1'b0;
        w_abortDone  = 1'b0;
        o_mst.valid  = 1'b0;
        o_mst.wstrb  = 4'h0;
        o_mst.addr   = 32'h0;
        o_mst.wdata  = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (r_len == '0) begin
                        w_emptyStart = 1'b1;
                    end else begin
                        w_launch    = 1'b1;
                        w_stateNext = S_RD;
                    end
                end
            end
            S_RD: begin
                o_mst.valid = 1'b1;
                o_mst.addr  = r_src;
                if (w_hs) begin
                    w_capture = 1'b1;
                    if (w_abortNow) begin
                        w_abortDone = 1'b1;
                        w_stateNext = S_IDLE;
                    end else begin
                        w_stateNext = S_WR;
                    end
                end
            end
            S_WR: begin
                o_mst.valid = 1'b1;
                o_mst.addr  = r_dst;
                o_mst.wstrb = 4'hF;
                o_mst.wdata = r_buf;
                if (w_hs) begin
                    w_wordDone = 1'b1;
                    if (w_lenNext == '0) begin
                        w_finish    = 1'b1;
                        w_stateNext = S_IDLE;
                    end else if (w_abortNow) begin
                        w_abortDone = 1'b1;
                        w_stateNext = S_IDLE;
                    end else begin
                        w_stateNext = S_RD;
                    end
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // State, counters, sticky status and irq; FSM updates override blocked cfg writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_src      <= 32'h0;
            r_dst      <= 32'h0;
            r_buf      <= 32'h0;
            r_len      <= '0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_dstFixed <= 1'b0;
            r_abortReq <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_irq   <= w_finish || w_abortDone || w_emptyStart;

            if (!w_busy) begin
                if (w_wrSrc) r_src <= {i_cfg.wdata[31:2], 2'b00};
                if (w_wrDst) r_dst <= {i_cfg.wdata[31:2], 2'b00};
                if (w_wrLen) r_len <= i_cfg.wdata[LEN_W-1:0];
            end

            if (w_launch) r_dstFixed <= i_cfg.wdata[1];
            if (w_capture) r_buf <= o_mst.rdata;

            if (w_wordDone) begin
                r_src <= r_src + 32'd4;
                if (!r_dstFixed) r_dst <= r_dst + 32'd4;
                r_len <= w_lenNext;
            end

            if (w_busy && (w_stateNext == S_IDLE)) begin
                r_abortReq <= 1'b0;
            end else if (w_busy && w_abortWr) begin
                r_abortReq <= 1'b1;
            end

            if (w_clearSticky) begin
                r_done    <= 1'b0;
                r_aborted <= 1'b0;
            end
            if (w_finish || w_emptyStart) r_done <= 1'b1;
            if (w_abortDone) r_aborted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_iomem_dma.sv
// Self-checking bench for iomem_dma: a stalling memory responder, a
// transaction scoreboard and directed scenarios with randomized addresses.
module tb_iomem_dma;

    localparam int LEN_W = 16;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] data;
    } txn_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic irq;

    iomem_dma_if #(.ADDR_W(4))  cfgBus ();
    iomem_dma_if #(.ADDR_W(32)) memBus ();

    iomem_dma #(.LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .i_cfg (cfgBus),
        .o_mst (memBus),
        .o_irq (irq)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatched = 0;
    int cyc = 0;
    int wrCyc = 0;

    int   maxStall = 0;
    int   stallQ[$];
    int   stallLeft = 0;
    bit   pend = 1'b0;
    logic [31:0] holdAddr;
    logic [31:0] holdWdata;
    logic [3:0]  holdWstrb;
    txn_t obsQ[$];
    txn_t expQ[$];
    int   txnStarted = 0;
    int   validCycles = 0;
    int   irqCount = 0;
    int   irqCyc = -1;
    int   lastHsCyc = -1;
    int   firstValidCyc = -1;

    // Free-running cycle count, advanced on the active edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Memory responder: random or scripted stalls, read data = addr ^ A5A5A5A5.
    always @(negedge clk) begin
        if (memBus.valid !== 1'b1) begin
            if (pend && !reset) checkOutput("validHeld", {31'h0, memBus.valid}, 32'h1);
            memBus.ready = 1'b0;
            pend = 1'b0;
        end else begin
            validCycles++;
            if (firstValidCyc < 0) firstValidCyc = cyc;
            if (pend) begin
                checkOutput("stallAddr", memBus.addr, holdAddr);
                checkOutput("stallWstrb", {28'h0, memBus.wstrb}, {28'h0, holdWstrb});
                checkOutput("stallWdata", memBus.wdata, holdWdata);
            end else begin
                txnStarted++;
                if (stallQ.size() > 0) stallLeft = stallQ.pop_front();
                else stallLeft = int'($urandom_range(maxStall, 0));
            end
            memBus.rdata = memBus.addr ^ 32'hA5A5_A5A5;
            if (stallLeft > 0) begin
                memBus.ready = 1'b0;
                stallLeft--;
            end else begin
                memBus.ready = 1'b1;
            end
            holdAddr  = memBus.addr;
            holdWstrb = memBus.wstrb;
            holdWdata = memBus.wdata;
            pend = !memBus.ready;
            if (memBus.ready) begin
                obsQ.push_back('{memBus.addr, memBus.wstrb, memBus.wdata});
                lastHsCyc = cyc;
            end
        end
        if (irq === 1'b1) begin
            irqCount++;
            irqCyc = cyc;
        end
    end

    task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        cfgBus.valid = 1'b1;
        cfgBus.wstrb = 4'hF;
        cfgBus.addr  = addr;
        cfgBus.wdata = data;
        wrCyc = cyc;
        @(negedge clk);
        cfgBus.valid = 1'b0;
        cfgBus.wstrb = 4'h0;
    endtask

    task automatic readReg(input logic [3:0] addr, output logic [31:0] data);
        #1;
        cfgBus.valid = 1'b1;
        cfgBus.wstrb = 4'h0;
        cfgBus.addr  = addr;
        #1;
        data = cfgBus.rdata;
        cfgBus.valid = 1'b0;
    endtask

    task automatic checkReg(input string tag, input logic [3:0] addr, input logic [31:0] expected);
        logic [31:0] value;
        readReg(addr, value);
        checkOutput(tag, value, expected);
    endtask

    task automatic resetScoreboard();
        obsQ.delete();
        expQ.delete();
        validCycles = 0;
        irqCount = 0;
        irqCyc = -1;
        firstValidCyc = -1;
        txnStarted = 0;
    endtask

    // Reference model: a copy of n words is n (read src+4i, write dst[+4i]) pairs.
    task automatic expectCopy(input logic [31:0] src, input logic [31:0] dst, input bit fixed, input int n);
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            a = src + 32'(4 * i);
            d = fixed ? dst : dst + 32'(4 * i);
            expQ.push_back('{a, 4'h0, 32'h0});
            expQ.push_back('{d, 4'hF, a ^ 32'hA5A5_A5A5});
        end
    endtask

    task automatic compareTxns(input string tag);
        checkOutput({tag, "Count"}, obsQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            checkOutput({tag, "Addr"}, obsQ[i].addr, expQ[i].addr);
            checkOutput({tag, "Wstrb"}, {28'h0, obsQ[i].wstrb}, {28'h0, expQ[i].wstrb});
            if (expQ[i].wstrb == 4'hF) checkOutput({tag, "Data"}, obsQ[i].data, expQ[i].data);
        end
    endtask

    task automatic waitIrq(input string tag, input int limit);
        int start;
        int n;
        start = irqCount;
        n = 0;
        while (irqCount == start && n < limit) begin
            @(negedge clk);
            #2;
            n++;
        end
        checkOutput({tag, "IrqSeen"}, {31'h0, irqCount != start}, 32'h1);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    // Hard stop if something hangs beyond every per-wait bound.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] src;
        logic [31:0] dst;
        int n;

        cfgBus.valid = 1'b0;
        cfgBus.wstrb = 4'h0;
        cfgBus.addr  = 4'h0;
        cfgBus.wdata = 32'h0;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checkOutput("rstValid", {31'h0, memBus.valid}, 32'h0);
        checkOutput("rstAddr", memBus.addr, 32'h0);
        checkOutput("rstWstrb", {28'h0, memBus.wstrb}, 32'h0);
        checkOutput("rstWdata", memBus.wdata, 32'h0);
        checkOutput("rstIrq", {31'h0, irq}, 32'h0);
        checkOutput("rstCfgReadyLow", {31'h0, cfgBus.ready}, 32'h0);
        cfgBus.valid = 1'b1;
        #1;
        checkOutput("rstCfgReadyHigh", {31'h0, cfgBus.ready}, 32'h1);
        cfgBus.valid = 1'b0;
        checkReg("rstSrc", 4'h0, 32'h0);
        checkReg("rstDst", 4'h4, 32'h0);
        checkReg("rstLen", 4'h8, 32'h0);
        checkReg("rstStatus", 4'hC, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Basic copy, 3 words, no stalls
        maxStall = 0;
        resetScoreboard();
        applyStimulus(4'h0, 32'h0000_0103);
        checkReg("srcAlign", 4'h0, 32'h0000_0100);
        applyStimulus(4'h4, 32'h0500_0000);
        applyStimulus(4'h8, 32'hFFFF_0003);
        checkReg("lenZext", 4'h8, 32'h3);
        applyStimulus(4'hC, 32'h1);
        n = wrCyc;
        waitIrq("basic", 50);
        checkReg("basicStatus", 4'hC, 32'h2);
        checkOutput("basicIrqTiming", irqCyc, lastHsCyc + 1);
        checkOutput("basicFirstValid", firstValidCyc, n + 1);
        checkOutput("basicLastHs", lastHsCyc, n + 6);
        @(negedge clk);
        #2;
        checkOutput("basicIrqLow", {31'h0, irq}, 32'h0);
        checkOutput("basicValidCycles", validCycles, 6);
        checkOutput("basicIrqCount", irqCount, 1);
        expectCopy(32'h0000_0100, 32'h0500_0000, 1'b0, 3);
        compareTxns("basic");
        checkReg("basicSrcEnd", 4'h0, 32'h0000_010C);
        checkReg("basicDstEnd", 4'h4, 32'h0500_000C);
        checkReg("basicLenEnd", 4'h8, 32'h0);

        // DST_FIXED with random stalls of 0..5 cycles
        applyStimulus(4'hC, 32'h8);
        resetScoreboard();
        src = $urandom & 32'h00FF_FFFC;
        maxStall = 5;
        applyStimulus(4'h0, src);
        applyStimulus(4'h4, 32'h0400_0000);
        applyStimulus(4'h8, 32'h4);
        applyStimulus(4'hC, 32'h3);
        waitIrq("fixed", 200);
        checkReg("fixedStatus", 4'hC, 32'hA);
        idleCycles(2);
        maxStall = 0;
        checkOutput("fixedIrqCount", irqCount, 1);
        expectCopy(src, 32'h0400_0000, 1'b1, 4);
        compareTxns("fixed");
        checkReg("fixedSrcEnd", 4'h0, src + 32'd16);
        checkReg("fixedDstEnd", 4'h4, 32'h0400_0000);

        // LEN=0 start: no traffic, DONE and irq next cycle
        applyStimulus(4'hC, 32'h8);
        resetScoreboard();
        applyStimulus(4'h8, 32'h0);
        applyStimulus(4'hC, 32'h1);
        n = wrCyc;
        waitIrq("len0", 10);
        checkOutput("len0IrqTiming", irqCyc, n + 1);
        checkReg("len0Status", 4'hC, 32'hA);
        idleCycles(3);
        checkOutput("len0ValidCycles", validCycles, 0);
        checkOutput("len0IrqCount", irqCount, 1);

        // ABORT during the second read, which stalls 3 cycles
        applyStimulus(4'hC, 32'h8);
        resetScoreboard();
        dst = $urandom & 32'hFFFF_FFFC;
        applyStimulus(4'h0, 32'h0000_0100);
        applyStimulus(4'h4, dst);
        applyStimulus(4'h8, 32'h3);
        stallQ = '{0, 0, 3};
        applyStimulus(4'hC, 32'h1);
        n = 0;
        while (txnStarted < 3 && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        checkOutput("abortReachedRd2", {31'h0, txnStarted >= 3}, 32'h1);
        applyStimulus(4'hC, 32'h4);
        waitIrq("abort", 20);
        idleCycles(4);
        checkReg("abortStatus", 4'hC, 32'h4);
        checkReg("abortLen", 4'h8, 32'h2);
        checkReg("abortSrc", 4'h0, 32'h0000_0104);
        checkReg("abortDst", 4'h4, dst + 32'd4);
        checkOutput("abortIrqCount", irqCount, 1);
        expectCopy(32'h0000_0100, dst, 1'b0, 1);
        expQ.push_back('{32'h0000_0104, 4'h0, 32'h0});
        compareTxns("abort");

        // ABORT written in IDLE has no effect
        resetScoreboard();
        applyStimulus(4'hC, 32'h4);
        idleCycles(3);
        checkReg("idleAbortStatus", 4'hC, 32'h4);
        checkOutput("idleAbortValid", validCycles, 0);
        checkOutput("idleAbortIrq", irqCount, 0);

        // Address wrap, START+ABORT together, DST write while busy
        applyStimulus(4'hC, 32'h8);
        resetScoreboard();
        dst = $urandom & 32'h0FFF_FFFC;
        maxStall = 2;
        applyStimulus(4'h0, 32'hFFFF_FFFC);
        applyStimulus(4'h4, dst);
        applyStimulus(4'h8, 32'h2);
        applyStimulus(4'hC, 32'h5);
        applyStimulus(4'h4, 32'h1234_5678);
        waitIrq("wrap", 100);
        checkReg("wrapStatus", 4'hC, 32'h2);
        maxStall = 0;
        expectCopy(32'hFFFF_FFFC, dst, 1'b0, 2);
        compareTxns("wrap");
        checkReg("wrapSrcEnd", 4'h0, 32'h0000_0004);
        checkReg("wrapDstEnd", 4'h4, dst + 32'd8);

        // Reset while a write is stalled on the bus
        resetScoreboard();
        applyStimulus(4'h0, 32'h0000_2000);
        applyStimulus(4'h4, 32'h0000_3000);
        applyStimulus(4'h8, 32'h5);
        stallQ = '{0, 20};
        applyStimulus(4'hC, 32'h1);
        n = 0;
        while (!(memBus.valid === 1'b1 && memBus.wstrb === 4'hF) && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        checkOutput("rstMidInWr", {31'h0, memBus.wstrb === 4'hF}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        #2;
        checkOutput("rstMidValid", {31'h0, memBus.valid}, 32'h0);
        checkOutput("rstMidIrq", {31'h0, irq}, 32'h0);
        checkReg("rstMidSrc", 4'h0, 32'h0);
        checkReg("rstMidDst", 4'h4, 32'h0);
        checkReg("rstMidLen", 4'h8, 32'h0);
        checkReg("rstMidStatus", 4'hC, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        stallQ.delete();
        idleCycles(2);
        checkOutput("rstMidStaysIdle", {31'h0, memBus.valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
